div_issue_ctrl: RTL

//   Upstream issue/sequencing stage for the multi-cycle signed divider div_16.
//   - Buffers divide requests from CPU decode with tags.
//   - Resolves the special cases locally: divide-by-zero and -32768/-1.
//   - Pulses the divider's start and captures quotient/remainder on done.
//   - Returns tagged results to the CPU writeback over a valid/ready handshake.

---
 rtl/div_issue_ctrl_pkg.sv | 25 ++
 rtl/div_req_fifo.sv | 55 +++++
 rtl/div_issue_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
// Holds the FSM encoding, error codes and the special-case operand test.
package div_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } div_state_e;

    localparam logic [1:0]  ERR_OK  = 2'b00;
    localparam logic [1:0]  ERR_DZ  = 2'b01;
    localparam logic [1:0]  ERR_TMO = 2'b10;

    localparam logic [15:0] INT_MIN = 16'h8000;
    localparam logic [15:0] Q_DZ    = 16'hFFFF;
    localparam logic [15:0] NEG_ONE = 16'hFFFF;

    // Operand pairs answered locally, never sent to the divider.
    function automatic logic is_special(input logic [15:0] dividend, input logic [15:0] divisor);
        return (divisor == 16'h0000) || (dividend == INT_MIN && divisor == NEG_ONE);
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Synchronous request FIFO with registered occupancy count.
// Push while full is only taken when a pop happens in the same cycle.
module div_req_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/sequencing stage in front of the div_16 signed divider.
// Queues tagged requests, resolves special cases locally, returns tagged results in order.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4,
    parameter int TMO   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_dividend,
    input  logic [15:0]      req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             div_start,
    output logic [15:0]      div_dividend,
    output logic [15:0]      div_divisor,
    input  logic [15:0]      div_quotient,
    input  logic [15:0]      div_remainder,
    input  logic             div_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_quotient,
    output logic [15:0]      rsp_remainder,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_err,
    output logic             busy,
    output div_state_e       dbg_state
);

    localparam int FW    = 32 + TAG_W;
    localparam int CNT_W = (TMO > 1) ? $clog2(TMO) : 1;

    div_state_e       state, state_nxt;
    logic             fifo_empty, fifo_full, fifo_pop, push;
    logic [FW-1:0]    fifo_rdata;
    logic [15:0]      head_dd, head_dv;
    logic [TAG_W-1:0] head_tag;
    logic [15:0]      w_dd, w_dv;
    logic [TAG_W-1:0] w_tag;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // Handshake: a request transfers on req_valid & req_ready at posedge, a response
    // on rsp_valid & rsp_ready at posedge; valid holds its payload until it transfers.
    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;

    div_req_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({req_dividend, req_divisor, req_tag}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign head_dd  = fifo_rdata[FW-1 -: 16];
    assign head_dv  = fifo_rdata[TAG_W +: 16];
    assign head_tag = fifo_rdata[TAG_W-1:0];

    // RESP hands straight over to the next entry when the consumer accepts.
    assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || (state == ST_RESP && rsp_ready));
    assign tmo_hit  = (state == ST_WAIT) && !div_done && (tmo_cnt == CNT_W'(TMO - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (fifo_pop) begin
                    state_nxt = is_special(head_dd, head_dv) ? ST_RESP : ST_ISSUE;
                end else if (state == ST_RESP && rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (div_done || tmo_hit) state_nxt = ST_RESP;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        div_start = (state == ST_ISSUE);
        rsp_valid = (state == ST_RESP);
        busy      = (state != ST_IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_dd          <= '0;
            w_dv          <= '0;
            w_tag         <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_err       <= ERR_OK;
            tmo_cnt       <= '0;
        end else begin
            if (fifo_pop) begin
                w_dd  <= head_dd;
                w_dv  <= head_dv;
                w_tag <= head_tag;
                if (head_dv == 16'h0000) begin
                    rsp_quotient  <= Q_DZ;
                    rsp_remainder <= head_dd;
                    rsp_err       <= ERR_DZ;
                end else if (head_dd == INT_MIN && head_dv == NEG_ONE) begin
                    rsp_quotient  <= INT_MIN;
                    rsp_remainder <= '0;
                    rsp_err       <= ERR_OK;
                end
            end else if (state == ST_WAIT) begin
                if (div_done) begin
                    rsp_quotient  <= div_quotient;
                    rsp_remainder <= div_remainder;
                    rsp_err       <= ERR_OK;
                end else if (tmo_hit) begin
                    rsp_quotient  <= '0;
                    rsp_remainder <= '0;
                    rsp_err       <= ERR_TMO;
                end
            end
            if (state == ST_ISSUE)     tmo_cnt <= '0;
            else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign div_dividend = w_dd;
    assign div_divisor  = w_dv;
    assign rsp_tag      = w_tag;
    assign dbg_state    = state;

endmodule
